// File: rtl/rs255_247_enc.sv
// Systematic RS(255,247) encoder over GF(2^8) (poly 0x11D, generator roots alpha^0..alpha^7).
// Define RS_ENC_MARKERS_EN to add the m_sop/m_eop framing outputs.
module rs255_247_enc #(
   parameter int unsigned K = 247
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       s_valid,
   output logic       s_ready,
   input  logic [7:0] s_data,
   output logic       m_valid,
   input  logic       m_ready,
   output logic [7:0] m_data,
`ifdef RS_ENC_MARKERS_EN
   output logic       m_sop,
   output logic       m_eop,
`endif
   output logic       busy
);

   localparam int unsigned NPAR = 8;
   // Wide enough for both the message index and the 0..7 parity index.
   localparam int unsigned CntW = ($clog2(K) > 3) ? $clog2(K) : 3;
   localparam logic [0:0] StMsg = 1'b0;
   localparam logic [0:0] StPar = 1'b1;

   function automatic logic [7:0] gf256mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
      end
      return p;
   endfunction

   // Expands prod (x + alpha^i); returns g0..g7 packed low to high (monic x^8 term dropped).
   function automatic logic [8*NPAR-1:0] gen_coef();
      logic [NPAR:0][7:0] g;
      logic [7:0]         root;
      g    = '0;
      g[0] = 8'h01;
      root = 8'h01;
      for (int i = 0; i < NPAR; i++) begin
         for (int d = NPAR; d > 0; d--) g[d] = g[d-1] ^ gf256mul(g[d], root);
         g[0] = gf256mul(g[0], root);
         root = gf256mul(root, 8'h02);
      end
      return g[NPAR-1:0];
   endfunction

   localparam logic [8*NPAR-1:0] GEN = gen_coef();

   logic [0:0]            state_q;
   logic [CntW-1:0]       cnt_q;
   logic [NPAR-1:0][7:0]  par_q;
   logic [NPAR-1:0][7:0]  lfsr_par;
   logic                  eop_q;
   logic                  busy_q;
   logic                  out_free;
   logic                  msg_acc;
   logic                  par_load;
   logic [7:0]            fb;

   assign out_free = !m_valid || m_ready;
   assign s_ready  = (state_q == StMsg) && out_free;
   assign msg_acc  = s_valid && s_ready;
   assign par_load = (state_q == StPar) && out_free;
   assign fb       = s_data ^ par_q[NPAR-1];
   assign busy     = busy_q;

   always_comb begin
      lfsr_par    = '0;
      lfsr_par[0] = gf256mul(fb, GEN[7:0]);
      for (int i = 1; i < NPAR; i++) begin
         lfsr_par[i] = par_q[i-1] ^ gf256mul(fb, GEN[8*i +: 8]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StMsg;
         cnt_q   <= '0;
         par_q   <= '0;
         m_valid <= 1'b0;
         m_data  <= 8'h00;
         eop_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         if (msg_acc) begin
            m_data  <= s_data;
            m_valid <= 1'b1;
            eop_q   <= 1'b0;
            par_q   <= lfsr_par;
            if (cnt_q == CntW'(K - 1)) begin
               cnt_q   <= '0;
               state_q <= StPar;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end else if (par_load) begin
            m_data  <= par_q[NPAR-1];
            m_valid <= 1'b1;
            eop_q   <= (cnt_q == CntW'(NPAR - 1));
            par_q   <= {par_q[NPAR-2:0], 8'h00};
            if (cnt_q == CntW'(NPAR - 1)) begin
               cnt_q   <= '0;
               state_q <= StMsg;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end else if (m_ready) begin
            m_valid <= 1'b0;
         end

         // A new codeword starting wins over the previous one finishing in the same cycle.
         if (msg_acc) begin
            busy_q <= 1'b1;
         end else if (m_valid && m_ready && eop_q) begin
            busy_q <= 1'b0;
         end
      end
   end

`ifdef RS_ENC_MARKERS_EN
   logic sop_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sop_q <= 1'b0;
      end else if (msg_acc) begin
         sop_q <= (cnt_q == '0);
      end else if (par_load) begin
         sop_q <= 1'b0;
      end
   end

   assign m_sop = sop_q;
   assign m_eop = eop_q;
`endif

endmodule

// File: tb/tb_rs255_247_enc.sv
// Scoreboard bench for rs255_247_enc: a K=247 instance and a shortened K=16 instance,
// checked against a GF(2^8) long-division reference built from log/antilog tables.
module tb_rs255_247_enc;

   localparam int unsigned KA = 247;
   localparam int unsigned KB = 16;

   typedef logic [7:0] bq_t[$];

   logic       clk = 1'b0;
   logic       rst;
   logic       s_valid, s_ready, m_valid, m_ready, busy;
   logic [7:0] s_data, m_data;
   logic       s_valid_b, s_ready_b, m_valid_b, m_ready_b, busy_b;
   logic [7:0] s_data_b, m_data_b;
`ifdef RS_ENC_MARKERS_EN
   logic       m_sop_b, m_eop_b, m_sop, m_eop;
`endif

   always #5 clk = ~clk;

   rs255_247_enc #(.K(KA)) u_dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
`ifdef RS_ENC_MARKERS_EN
      .m_sop(m_sop), .m_eop(m_eop),
`endif
      .busy(busy)
   );

   rs255_247_enc #(.K(KB)) u_dut_b (
      .clk(clk), .rst(rst), .s_valid(s_valid_b), .s_ready(s_ready_b), .s_data(s_data_b),
      .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b),
`ifdef RS_ENC_MARKERS_EN
      .m_sop(m_sop_b), .m_eop(m_eop_b),
`endif
      .busy(busy_b)
   );

   int         vectors = 0;
   int         miscompares = 0;
   logic [7:0] exp_t[256];
   int         log_t[256];
   logic [7:0] gpoly[9];
   bq_t        exp_a, got_a, exp_b, got_b, msg_a;
   bit         rand_ready = 1'b0;
   bit         gaps = 1'b0;
   int         run_a = 0, max_run_a = 0, run_b = 0, max_run_b = 0, idx_b = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      if (a == 8'h00 || b == 8'h00) return 8'h00;
      return exp_t[(log_t[a] + log_t[b]) % 255];
   endfunction

   // Codeword = message followed by remainder of m(x)*x^8 divided by g(x).
   function automatic bq_t encode(bq_t m);
      bq_t b;
      b = m;
      for (int j = 0; j < 8; j++) b.push_back(8'h00);
      for (int i = 0; i < m.size(); i++) begin
         logic [7:0] c;
         c = b[i];
         for (int j = 1; j <= 8; j++) b[i+j] = b[i+j] ^ gm(c, gpoly[8-j]);
      end
      for (int i = 0; i < m.size(); i++) b[i] = m[i];
      return b;
   endfunction

   function automatic logic [63:0] syndromes(bq_t cw);
      logic [63:0] r;
      r = '0;
      for (int k = 0; k < 8; k++) begin
         logic [7:0] s;
         s = 8'h00;
         foreach (cw[i]) s = gm(s, exp_t[k]) ^ cw[i];
         r[8*k +: 8] = s;
      end
      return r;
   endfunction

   function automatic logic [63:0] parity_of(bq_t cw, int k);
      logic [63:0] p;
      p = '0;
      for (int j = 0; j < 8; j++) p = {p[55:0], cw[k+j]};
      return p;
   endfunction

   task automatic send_a(input int nsend);
      bq_t cw;
      int  w;
      cw = encode(msg_a);
      for (int i = 0; i < ((nsend == int'(KA)) ? int'(KA) + 8 : nsend); i++) exp_a.push_back(cw[i]);
      for (int i = 0; i < nsend; i++) begin
         s_valid = 1'b1;
         s_data  = msg_a[i];
         w = 0;
         @(negedge clk);
         while (!s_ready && w < 1000) begin
            @(negedge clk);
            w++;
         end
         if (w >= 1000) begin
            vectors++;
            miscompares++;
            $display("FAIL a_s_ready_timeout: got 0, required 1");
            s_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
         s_valid = 1'b0;
         s_data  = $urandom_range(0, 255);
         if (gaps) repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic drain(input bit which);
      int w;
      w = 0;
      while ((which ? exp_b.size() : exp_a.size()) != 0 && w < 5000) begin
         @(posedge clk);
         #1;
         w++;
      end
      if (w >= 5000) begin
         vectors++;
         miscompares++;
         $display("FAIL drain_timeout: got %0d left, required 0",
                  which ? exp_b.size() : exp_a.size());
      end
      repeat (2) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor for the K=247 instance; also checks output stability while stalled.
   initial begin
      bit         hold_v;
      logic [7:0] hold_d;
      hold_v = 1'b0;
      hold_d = 8'h00;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold_v = 1'b0;
            run_a  = 0;
         end else begin
            if (hold_v) check("a_stall_hold", 64'({m_valid, m_data}), 64'({1'b1, hold_d}));
            hold_v = m_valid && !m_ready;
            hold_d = m_data;
            if (m_valid) begin
               run_a++;
               if (run_a > max_run_a) max_run_a = run_a;
            end else begin
               run_a = 0;
            end
            if (m_valid && m_ready) begin
               got_a.push_back(m_data);
               if (exp_a.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL a_unexpected: got %0h, required no output", m_data);
               end else begin
                  check("a_data", 64'(m_data), 64'(exp_a.pop_front()));
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            run_b = 0;
            idx_b = 0;
         end else begin
            if (m_valid_b) begin
               run_b++;
               if (run_b > max_run_b) max_run_b = run_b;
            end else begin
               run_b = 0;
            end
            if (m_valid_b && m_ready_b) begin
               got_b.push_back(m_data_b);
`ifdef RS_ENC_MARKERS_EN
               check("b_markers", 64'({m_sop_b, m_eop_b}),
                     64'({idx_b % 24 == 0, idx_b % 24 == 23}));
`endif
               idx_b++;
               if (exp_b.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL b_unexpected: got %0h, required no output", m_data_b);
               end else begin
                  check("b_data", 64'(m_data_b), 64'(exp_b.pop_front()));
               end
            end
         end
      end
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] x;
      bq_t        cwa, cwb, cwc, msg_b, cw;
      int         bad;
      logic [7:0] orv;
      int         w;

      x = 8'h01;
      for (int i = 0; i < 255; i++) begin
         exp_t[i] = x;
         log_t[x] = i;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
      end
      exp_t[255] = 8'h01;
      for (int d = 0; d < 9; d++) gpoly[d] = 8'h00;
      gpoly[0] = 8'h01;
      for (int i = 0; i < 8; i++) begin
         for (int d = 8; d > 0; d--) gpoly[d] = gpoly[d-1] ^ gm(gpoly[d], exp_t[i]);
         gpoly[0] = gm(gpoly[0], exp_t[i]);
      end

      rst = 1'b1;
      s_valid = 1'b0; s_data = 8'h00;
      s_valid_b = 1'b0; s_data_b = 8'h00; m_ready_b = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", 64'({m_valid, m_data, busy, s_ready}), 64'({1'b0, 8'h00, 1'b0, 1'b1}));
      rst = 1'b0;
      @(posedge clk);
      #1;

      // 1: all-zero message
      msg_a = {};
      for (int i = 0; i < int'(KA); i++) msg_a.push_back(8'h00);
      got_a = {}; max_run_a = 0;
      send_a(KA);
      drain(1'b0);
      orv = 8'h00;
      foreach (got_a[i]) orv = orv | got_a[i];
      check("t1_count", 64'(got_a.size()), 64'd255);
      check("t1_zero", 64'(orv), 64'd0);
      check("t1_run", 64'(max_run_a), 64'd255);
      check("t1_busy", 64'(busy), 64'd0);

      // 2: single 0x01 in the last message position yields the generator coefficients
      msg_a[KA-1] = 8'h01;
      got_a = {};
      send_a(KA);
      drain(1'b0);
      check("t2_first_par", 64'(got_a[KA]), 64'hFF);
      check("t2_last_par", 64'(got_a[KA+7]), 64'h18);
      for (int j = 0; j < 8; j++) check("t2_gen", 64'(got_a[KA+j]), 64'(gpoly[7-j]));

      // 3: linearity and syndromes
      msg_a = {};
      for (int i = 0; i < int'(KA); i++) msg_a.push_back(8'($urandom_range(0, 255)));
      msg_b = msg_a;
      got_a = {}; send_a(KA); drain(1'b0); cwa = got_a;
      for (int i = 0; i < int'(KA); i++) msg_a[i] = 8'($urandom_range(0, 255));
      got_a = {}; send_a(KA); drain(1'b0); cwb = got_a;
      for (int i = 0; i < int'(KA); i++) msg_a[i] = msg_b[i] ^ msg_a[i];
      got_a = {}; send_a(KA); drain(1'b0); cwc = got_a;
      check("t3_linear", parity_of(cwc, KA), parity_of(cwa, KA) ^ parity_of(cwb, KA));
      check("t3_synd_a", syndromes(cwa), 64'd0);
      check("t3_synd_b", syndromes(cwb), 64'd0);
      check("t3_synd_c", syndromes(cwc), 64'd0);

      // 4: message A again under random backpressure and input gaps
      msg_a = msg_b;
      rand_ready = 1'b1; gaps = 1'b1;
      got_a = {};
      send_a(KA);
      drain(1'b0);
      rand_ready = 1'b0; gaps = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      bad = (got_a.size() != cwa.size()) ? 1 : 0;
      for (int i = 0; i < got_a.size() && i < cwa.size(); i++) if (got_a[i] !== cwa[i]) bad++;
      check("t4_stream", 64'(bad), 64'd0);

      // 5: asynchronous reset mid-message, then a clean codeword
      for (int i = 0; i < int'(KA); i++) msg_a[i] = 8'($urandom_range(0, 255));
      send_a(100);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("t5_async_rst", 64'({m_valid, m_data, busy}), 64'd0);
      check("t5_flush", 64'(exp_a.size()), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < int'(KA); i++) msg_a[i] = 8'($urandom_range(0, 255));
      got_a = {};
      send_a(KA);
      drain(1'b0);
      check("t5_count", 64'(got_a.size()), 64'd255);
      check("t5_synd", syndromes(got_a), 64'd0);

      // 6: shortened K=16, two frames back to back
      got_b = {}; max_run_b = 0;
      msg_b = {};
      for (int f = 0; f < 2; f++) begin
         bq_t m;
         m = {};
         for (int i = 0; i < int'(KB); i++) m.push_back(8'($urandom_range(0, 255)));
         cw = encode(m);
         foreach (cw[i]) exp_b.push_back(cw[i]);
         foreach (m[i]) msg_b.push_back(m[i]);
      end
      foreach (msg_b[i]) begin
         s_valid_b = 1'b1;
         s_data_b  = msg_b[i];
         w = 0;
         @(negedge clk);
         while (!s_ready_b && w < 100) begin
            @(negedge clk);
            w++;
         end
         if (w >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL b_s_ready_timeout: got 0, required 1");
            break;
         end
         @(posedge clk);
         #1;
      end
      s_valid_b = 1'b0;
      drain(1'b1);
      check("t6_count", 64'(got_b.size()), 64'd48);
      check("t6_gapless", 64'(max_run_b), 64'd48);
      check("t6_busy", 64'(busy_b), 64'd0);
      check("t6_synd", syndromes(got_b[0:23]), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
